rf_write_arbiter: RTL

- Shares the register file's single write port between two requesters:
  - the WB stage of the 5-stage pipeline;
  - the long-latency unit (LU: mul/div) through a small FIFO.
- Normally WB has priority. The LU head entry is granted when WB is idle; a starvation counter forces an LU grant and stalls WB.
- Outputs are registered and drive the register file's reg_write/rd/write_data inputs directly.

---
 rtl/rf_write_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the register file's single write port between the WB stage of the
//   pipeline and the long-latency unit (mul/div). LU results are buffered in
//   a small FIFO. WB normally wins; the LU head is written whenever WB is
//   idle. If the head has waited MAX_WAIT cycles, WB is stalled for one cycle
//   and the head is forced through. The write port outputs are registered and
//   drive the register file's reg_write/rd/write_data inputs directly.
//
// Optional feature (macro RF_WARB_PENDING_MASK_EN):
//   Adds output lu_pending_mask[31:0]. Bit i is set when any buffered LU
//   entry targets register i, so the hazard unit can stall readers of that
//   register. Bit 0 is always clear. Without the macro the port is absent.
//
// Ports:
//   clk            clock, all state on rising edge
//   rst            asynchronous active-high reset
//   wb_we/wb_rd/wb_data     WB write request (rd==0 means no write)
//   wb_stall       WB must hold its request; it is ignored this cycle
//   lu_valid/lu_rd/lu_data  LU result, transferred on lu_valid & lu_ready
//   lu_ready       FIFO has room
//   rf_reg_write/rf_rd/rf_write_data  registered register file write port
//   lu_count       FIFO occupancy
module rf_write_arbiter #(
  parameter int LU_DEPTH = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_we,
  input  logic [4:0]                 wb_rd,
  input  logic [31:0]                wb_data,
  output logic                       wb_stall,
  input  logic                       lu_valid,
  input  logic [4:0]                 lu_rd,
  input  logic [31:0]                lu_data,
  output logic                       lu_ready,
  output logic                       rf_reg_write,
  output logic [4:0]                 rf_rd,
  output logic [31:0]                rf_write_data,
  output logic [$clog2(LU_DEPTH):0]  lu_count
`ifdef RF_WARB_PENDING_MASK_EN
  ,
  output logic [31:0]                lu_pending_mask
`endif
);

  localparam int PTR_W  = $clog2(LU_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(LU_DEPTH);
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_WB,
    GRANT_LU
  } grant_e;

  logic [4:0]        rd_mem   [LU_DEPTH];
  logic [31:0]       data_mem [LU_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [WAIT_W-1:0] wait_cnt;

  grant_e            grant;
  logic [4:0]        grant_rd;
  logic [31:0]       grant_data;
  logic              wb_req;
  logic              push;
  logic              pop;

  assign wb_req   = wb_we & (wb_rd != 5'd0);
  // Both are taken from registered state only: a pop in the same cycle does
  // not open a slot, and the stall never depends on this cycle's requests.
  assign lu_ready = (count < DEPTH_C);
  assign wb_stall = (count != '0) && (wait_cnt >= MAX_WAIT_C);
  // Writes to x0 complete the handshake but are never buffered.
  assign push     = lu_valid & lu_ready & (lu_rd != 5'd0);
  assign pop      = (grant == GRANT_LU);
  assign lu_count = count;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant      = GRANT_NONE;
    grant_rd   = rd_mem[rd_ptr];
    grant_data = data_mem[rd_ptr];
    if (wb_stall) begin
      grant = GRANT_LU;
    end else if (wb_req) begin
      grant      = GRANT_WB;
      grant_rd   = wb_rd;
      grant_data = wb_data;
    end else if (count != '0) begin
      grant = GRANT_LU;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      wait_cnt      <= '0;
      rf_reg_write  <= 1'b0;
      rf_rd         <= 5'd0;
      rf_write_data <= 32'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (count == '0 || pop) begin
        wait_cnt <= '0;
      end else if (wait_cnt < MAX_WAIT_C) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      rf_reg_write <= (grant != GRANT_NONE);
      if (grant != GRANT_NONE) begin
        rf_rd         <= grant_rd;
        rf_write_data <= grant_data;
      end
    end
  end

  // NOTE: the FIFO storage is not reset; occupancy and pointers define which
  // entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= lu_rd;
      data_mem[wr_ptr] <= lu_data;
    end
  end

`ifdef RF_WARB_PENDING_MASK_EN
  logic [PTR_W-1:0] offs;

  // An entry is live when its distance from the read pointer is below the
  // occupancy; only live entries contribute to the mask.
  always_comb begin
    lu_pending_mask = '0;
    offs            = '0;
    for (int i = 0; i < LU_DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr;
      if ({1'b0, offs} < count) lu_pending_mask[rd_mem[i]] = 1'b1;
    end
    lu_pending_mask[0] = 1'b0;
  end
`else
  // Pending mask disabled: no port and no mask logic.
`endif

endmodule
